// File: rtl/activation_collector.sv
`default_nettype none
// ============================================================================
//  Module   : activation_collector
//  Purpose  : Collects CELL_AMOUNT indexed activations from the ReLU write
//             stream into a two-bank (ping-pong) buffer. Each completed
//             vector is streamed in index order over valid/ready.
//  Ports    : clk, reset_n (async active-low)
//             input_index/input_value/input_enable : ReLU write stream
//             output_data/output_valid/output_ready/output_last : vector out
//             buffer_full    : both banks complete and unread
//             overflow_error : sticky, write hit a still-unread bank
//             index_error    : sticky, input_index >= CELL_AMOUNT
//             dup_error      : sticky, duplicate index write
//  Options  : `define ACTIVATION_COLLECTOR_DUP_DETECT_EN drops duplicate
//             writes and reports them on dup_error; otherwise duplicates
//             overwrite silently and dup_error is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module activation_collector #(
  parameter int DATA_WIDTH  = 8,
  parameter int CELL_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] input_index,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic                  input_enable,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic                  output_last,
  output logic                  buffer_full,
  output logic                  overflow_error,
  output logic                  index_error,
  output logic                  dup_error
);

  localparam int                   AW       = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam logic [AW-1:0]         LAST_IDX = AW'(CELL_AMOUNT - 1);
  localparam logic [CELL_AMOUNT-1:0] FULL_MAP = '1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Bank storage is deliberately not reset.
  logic [DATA_WIDTH-1:0]       mem_q [2][CELL_AMOUNT];

  logic [1:0][CELL_AMOUNT-1:0] bitmap_q, bitmap_d;
  logic [1:0]                  ready_q, ready_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  state_t                      state_q, state_d;
  logic [AW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic                        idx_err_q, idx_err_d;

  logic                        w_index_ok;
  logic                        w_dup;
  logic                        w_write;
  logic [AW-1:0]               w_addr;
  logic [CELL_AMOUNT-1:0]      w_onehot;
  logic [CELL_AMOUNT-1:0]      w_map_next;

  assign w_index_ok = (input_index < DATA_WIDTH'(CELL_AMOUNT));
  assign w_addr     = input_index[AW-1:0];
  assign w_onehot   = CELL_AMOUNT'(1) << w_addr;

`ifdef ACTIVATION_COLLECTOR_DUP_DETECT_EN
  logic dup_q, dup_d;
  assign w_dup     = bitmap_q[wr_bank_q][w_addr];
  assign dup_error = dup_q;
`else
  assign w_dup     = 1'b0;
  assign dup_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ready_d    = ready_q;
    rd_bank_d  = rd_bank_q;
    wr_bank_d  = wr_bank_q;
    bitmap_d   = bitmap_q;
    ovf_d      = ovf_q;
    idx_err_d  = idx_err_q;
    w_write    = 1'b0;
    w_map_next = '0;
`ifdef ACTIVATION_COLLECTOR_DUP_DETECT_EN
    dup_d      = dup_q;
`endif

    // Read side first, so that a release on this edge is already visible
    // in ready_d when the write side checks its target bank.
    case (state_q)
      S_IDLE: begin
        if (ready_q[rd_bank_q]) begin
          state_d = S_STREAM;
          count_d = '0;
        end
      end
      S_STREAM: begin
        if (output_ready) begin
          if (count_q == LAST_IDX) begin
            ready_d[rd_bank_q] = 1'b0;
            rd_bank_d          = ~rd_bank_q;
            state_d            = S_IDLE;
            count_d            = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (input_enable) begin
      if (!w_index_ok) begin
        idx_err_d = 1'b1;
      end else if (ready_d[wr_bank_q]) begin
        ovf_d = 1'b1;
      end else if (w_dup) begin
`ifdef ACTIVATION_COLLECTOR_DUP_DETECT_EN
        dup_d = 1'b1;
`endif
      end else begin
        w_write    = 1'b1;
        w_map_next = bitmap_q[wr_bank_q] | w_onehot;
        if (w_map_next == FULL_MAP) begin
          // Completion: hand the bank to the reader and move to the other one.
          ready_d[wr_bank_q]  = 1'b1;
          bitmap_d[wr_bank_q] = '0;
          wr_bank_d           = ~wr_bank_q;
        end else begin
          bitmap_d[wr_bank_q] = w_map_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      ready_q   <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      bitmap_q  <= '0;
      ovf_q     <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      bitmap_q  <= bitmap_d;
      ovf_q     <= ovf_d;
      idx_err_q <= idx_err_d;
    end
  end

`ifdef ACTIVATION_COLLECTOR_DUP_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dup_q <= 1'b0;
    end else begin
      dup_q <= dup_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_write) begin
      mem_q[wr_bank_q][w_addr] <= input_value;
    end
  end

  assign output_valid   = (state_q == S_STREAM);
  assign output_last    = output_valid && (count_q == LAST_IDX);
  assign output_data    = output_valid ? mem_q[rd_bank_q][count_q] : '0;
  assign buffer_full    = ready_q[0] & ready_q[1];
  assign overflow_error = ovf_q;
  assign index_error    = idx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_activation_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_activation_collector
//  Purpose  : Self-checking bench for activation_collector: a cycle table,
//             hand-written corner sequences and a randomized run compared
//             against a queue-based vector model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_activation_collector;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef ACTIVATION_COLLECTOR_DUP_DETECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] input_index;
  logic [DW-1:0] input_value;
  logic          input_enable;
  logic [DW-1:0] output_data;
  logic          output_valid;
  logic          output_ready;
  logic          output_last;
  logic          buffer_full;
  logic          overflow_error;
  logic          index_error;
  logic          dup_error;

  activation_collector #(.DATA_WIDTH(DW), .CELL_AMOUNT(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .input_index    (input_index),
    .input_value    (input_value),
    .input_enable   (input_enable),
    .output_data    (output_data),
    .output_valid   (output_valid),
    .output_ready   (output_ready),
    .output_last    (output_last),
    .buffer_full    (buffer_full),
    .overflow_error (overflow_error),
    .index_error    (index_error),
    .dup_error      (dup_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic          en;
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
  } row_t;

  row_t tbl [19];

  task automatic set_row(input int i, input int en, input int idx, input int val,
                         input int rdy, input int ev, input int ed, input int el);
    tbl[i].en  = 1'(en);
    tbl[i].idx = DW'(idx);
    tbl[i].val = DW'(val);
    tbl[i].rdy = 1'(rdy);
    tbl[i].ev  = 1'(ev);
    tbl[i].ed  = DW'(ed);
    tbl[i].el  = 1'(el);
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int val);
    @(negedge clk);
    input_enable = 1'b1;
    input_index  = DW'(idx);
    input_value  = DW'(val);
    @(posedge clk);
    #1;
    input_enable = 1'b0;
  endtask

  // Expects a full vector; element k sits at vec[31-8k -: 8].
  task automatic expect_vec(input string name, input logic [31:0] vec, input int budget);
    int w;
    w = 0;
    while (!output_valid && w < budget) begin
      tick();
      w++;
    end
    chk({name, "_start"}, 32'(output_valid), 32'd1);
    if (output_valid) begin
      for (int k = 0; k < N; k++) begin
        chk({name, "_valid"}, 32'(output_valid), 32'd1);
        chk({name, "_data"}, 32'(output_data), 32'(vec[31-8*k -: 8]));
        chk({name, "_last"}, 32'(output_last), 32'(k == N-1));
        tick();
      end
      chk({name, "_gap"}, 32'(output_valid), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(output_valid), 32'd0);
    chk({name, "_data"},  32'(output_data), 32'd0);
    chk({name, "_last"},  32'(output_last), 32'd0);
    chk({name, "_full"},  32'(buffer_full), 32'd0);
    chk({name, "_ovf"},   32'(overflow_error), 32'd0);
    chk({name, "_idx"},   32'(index_error), 32'd0);
    chk({name, "_dup"},   32'(dup_error), 32'd0);
  endtask

  // ---------------------------------------------------------------- model
  // Completed-but-unreleased vectors in arrival order; element k at [8k+:8].
  logic [N*DW-1:0] m_q[$];
  logic [DW-1:0]   m_part [N];
  bit              m_have [N];
  bit              m_stream;
  int              m_pos;
  bit              m_ovf, m_idx, m_dup;

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < N; k++) m_have[k] = 1'b0;
    m_stream = 1'b0;
    m_pos    = 0;
    m_ovf    = 1'b0;
    m_idx    = 1'b0;
    m_dup    = 1'b0;
  endtask

  task automatic model_step(input bit en, input int idx, input logic [DW-1:0] val, input bit rdy);
    int pend;
    bit all;
    logic [N*DW-1:0] v;
    pend = m_q.size();
    if (m_stream) begin
      if (rdy) begin
        if (m_pos == N-1) begin
          m_q.delete(0);
          m_stream = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end else if (pend > 0) begin
      m_stream = 1'b1;
      m_pos    = 0;
    end
    if (en) begin
      if (idx >= N) m_idx = 1'b1;
      else if (m_q.size() >= 2) m_ovf = 1'b1;
      else if (DUP_EN && m_have[idx]) m_dup = 1'b1;
      else begin
        m_part[idx] = val;
        m_have[idx] = 1'b1;
        all = 1'b1;
        for (int k = 0; k < N; k++) if (!m_have[k]) all = 1'b0;
        if (all) begin
          v = '0;
          for (int k = 0; k < N; k++) begin
            v[8*k +: 8] = m_part[k];
            m_have[k]   = 1'b0;
          end
          m_q.push_back(v);
        end
      end
    end
  endtask

  task automatic model_compare();
    logic [DW-1:0] ed;
    ed = m_stream ? m_q[0][8*m_pos +: 8] : '0;
    chk("rnd_valid", 32'(output_valid), 32'(m_stream));
    chk("rnd_data",  32'(output_data), 32'(ed));
    chk("rnd_last",  32'(output_last), 32'(m_stream && m_pos == N-1));
    chk("rnd_full",  32'(buffer_full), 32'(m_q.size() == 2));
    chk("rnd_ovf",   32'(overflow_error), 32'(m_ovf));
    chk("rnd_idx",   32'(index_error), 32'(m_idx));
    chk("rnd_dup",   32'(dup_error), 32'(m_dup));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  initial begin
    bit            r_en, r_rdy;
    int            r_idx;
    logic [DW-1:0] r_val;

    //          i   en idx val rdy  ev  ed el
    set_row( 0, 1, 0, 5, 1,   0, 0, 0);
    set_row( 1, 1, 1, 0, 1,   0, 0, 0);
    set_row( 2, 1, 2, 7, 1,   0, 0, 0);
    set_row( 3, 1, 3, 9, 1,   0, 0, 0);
    set_row( 4, 0, 0, 0, 1,   1, 5, 0);
    set_row( 5, 0, 0, 0, 1,   1, 0, 0);
    set_row( 6, 0, 0, 0, 1,   1, 7, 0);
    set_row( 7, 0, 0, 0, 1,   1, 9, 1);
    set_row( 8, 0, 0, 0, 1,   0, 0, 0);
    set_row( 9, 1, 2, 2, 1,   0, 0, 0);
    set_row(10, 1, 0, 0, 1,   0, 0, 0);
    set_row(11, 1, 3, 3, 1,   0, 0, 0);
    set_row(12, 1, 1, 1, 1,   0, 0, 0);
    set_row(13, 0, 0, 0, 0,   1, 0, 0);
    set_row(14, 0, 0, 0, 0,   1, 0, 0);
    set_row(15, 0, 0, 0, 1,   1, 1, 0);
    set_row(16, 0, 0, 0, 1,   1, 2, 0);
    set_row(17, 0, 0, 0, 1,   1, 3, 1);
    set_row(18, 0, 0, 0, 1,   0, 0, 0);

    reset_n      = 1'b0;
    input_enable = 1'b0;
    input_index  = '0;
    input_value  = '0;
    output_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // In-order then out-of-order fill with a short stall.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      input_enable = tbl[i].en;
      input_index  = tbl[i].idx;
      input_value  = tbl[i].val;
      output_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(output_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  32'(output_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_last", i),  32'(output_last), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_full", i),  32'(buffer_full), 32'd0);
      chk($sformatf("tbl%0d_err", i),   32'({overflow_error, index_error, dup_error}), 32'd0);
    end
    input_enable = 1'b0;

    // Bad index: ignored, must not touch any bitmap bit.
    output_ready = 1'b1;
    wr(4, 8'h55);
    chk("badidx_flag",  32'(index_error), 32'd1);
    chk("badidx_valid", 32'(output_valid), 32'd0);
    wr(1, 21);
    wr(2, 22);
    wr(3, 23);
    tick();
    chk("badidx_noout1", 32'(output_valid), 32'd0);
    tick();
    chk("badidx_noout2", 32'(output_valid), 32'd0);
    wr(0, 20);
    expect_vec("badidx_vec", 32'h14151617, 2);

    // Duplicate index write.
    wr(1, 3);
    wr(1, 6);
    wr(0, 10);
    wr(2, 12);
    wr(3, 13);
    expect_vec("dup_vec", DUP_EN ? 32'h0A030C0D : 32'h0A060C0D, 2);
    chk("dup_flag", 32'(dup_error), 32'(DUP_EN));

    // Backpressure, buffer_full and overflow.
    output_ready = 1'b0;
    for (int k = 0; k < N; k++) wr(k, k + 1);
    for (int k = 0; k < N; k++) wr(k, k + 5);
    chk("bp_full",     32'(buffer_full), 32'd1);
    chk("bp_ovf0",     32'(overflow_error), 32'd0);
    chk("bp_valid",    32'(output_valid), 32'd1);
    wr(0, 99);
    chk("bp_ovf1",     32'(overflow_error), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall_data", 32'(output_data), 32'd1);
      chk("bp_stall_valid", 32'(output_valid), 32'd1);
      tick();
    end
    output_ready = 1'b1;
    expect_vec("bp_vecA", 32'h01020304, 1);
    chk("bp_full_after_a", 32'(buffer_full), 32'd0);
    expect_vec("bp_vecB", 32'h05060708, 1);
    chk("bp_full_after_b", 32'(buffer_full), 32'd0);

    // Reset in the middle of a vector.
    for (int k = 0; k < N; k++) wr(k, 31 + k);
    tick();
    chk("rst_mid_valid", 32'(output_valid), 32'd1);
    tick();
    tick();
    chk("rst_mid_data", 32'(output_data), 32'd33);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_after_valid", 32'(output_valid), 32'd0);
    for (int k = 0; k < N; k++) wr(k, 41 + k);
    expect_vec("rst_fresh", 32'h292A2B2C, 2);

    // Randomized run against the vector model.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      model_compare();
      r_en  = ($urandom_range(0, 99) < 60);
      r_idx = ($urandom_range(0, 63) == 0) ? int'($urandom_range(4, 255))
                                           : int'($urandom_range(0, N-1));
      r_val = DW'($urandom);
      r_rdy = ($urandom_range(0, 99) < 55);
      input_enable = r_en;
      input_index  = DW'(r_idx);
      input_value  = r_val;
      output_ready = r_rdy;
      @(posedge clk);
      model_step(r_en, r_idx, r_val, r_rdy);
    end
    @(negedge clk);
    model_compare();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/activation_collector.md
Name: activation_collector

Overview:
- Receiving end of the ReLU cell's write stream (index, value, enable).
- Gathers CELL_AMOUNT indexed activations into a vector inside a two-bank (ping-pong) buffer.
- Streams each completed vector, in index order, to the next layer over a valid/ready handshake.
- Sits between the ReLU output stage and the next layer's input feeder.

Parameters:
- DATA_WIDTH, 8, width of the index and value buses.
- CELL_AMOUNT, 4, number of entries per vector (indices 0..CELL_AMOUNT-1).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- input_index  input  DATA_WIDTH  entry index of the incoming activation
- input_value  input  DATA_WIDTH  activation value
- input_enable  input  1  qualifies input_index/input_value for one cycle
- output_data  output  DATA_WIDTH  current streamed element
- output_valid  output  1  output_data is valid
- output_ready  input  1  downstream accepts the beat
- output_last  output  1  marks the final element of a vector
- buffer_full  output  1  both banks complete and awaiting read
- overflow_error  output  1  sticky: write dropped because the target bank is still unread
- index_error  output  1  sticky: input_index >= CELL_AMOUNT
- dup_error  output  1  sticky: duplicate index (optional feature)

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0; both bank bitmaps and ready flags cleared; wr_bank=0, rd_bank=0; read FSM in IDLE; element count 0. Buffer contents are not cleared; output_data is forced to 0 whenever output_valid=0.
- Each bank has CELL_AMOUNT x DATA_WIDTH storage, a CELL_AMOUNT-bit fill bitmap and a ready flag.
- Write side (each edge with input_enable=1):
  - input_index >= CELL_AMOUNT: write ignored, index_error set.
  - Else if ready[wr_bank]=1 and the reader is not releasing that bank this cycle: write dropped, overflow_error set.
  - Else: store the value, set the bitmap bit.
  - If the bitmap becomes all ones: ready[wr_bank]<=1, bitmap cleared, wr_bank toggles, all on the same edge.
- Index arrival order is free. An in-order ReLU sequence 0..CELL_AMOUNT-1 completes a bank on the last write.
- Read FSM:
  - IDLE: when ready[rd_bank]=1, go to STREAM with count=0; output_valid rises on that edge. Latency from the completing write edge to output_valid high is 1 cycle.
  - STREAM: output_valid=1; output_data=bank[rd_bank][count]; output_last=(count==CELL_AMOUNT-1).
  - On output_valid & output_ready: count++. On the last beat, ready[rd_bank]<=0, rd_bank toggles, and the FSM goes to IDLE. A back-to-back ready bank re-enters STREAM on the next edge, giving a 1-cycle gap between vectors.
  - output_valid, once high, stays high and output_data stays stable until accepted.
- Simultaneous events:
  - Reader release and a write to the same bank on one edge: release wins and the write is accepted.
  - Completion and release of the other bank on one edge: both take effect.
- buffer_full = ready[0] & ready[1], registered-equivalent (from flops only).
- Error flags clear only on reset.
- Reset mid-stream aborts the vector. output_valid drops immediately (asynchronous).

Optional Feature:
- Macro ACTIVATION_COLLECTOR_DUP_DETECT_EN.
- Defined: a write to an entry whose bitmap bit is already set is dropped, sets dup_error, and does not affect completion.
- Undefined: the duplicate silently overwrites the value, and dup_error is tied to 0.

Test Plan:
- In-order fill: writes idx 0..3 with values 5,0,7,9; output_ready=1 -> output_valid high 1 cycle after the idx-3 write; beats 5,0,7,9; output_last only on 9.
- Out-of-order fill: writes idx 2,0,3,1 with values 2,0,3,1 -> stream 0,1,2,3; no errors.
- Backpressure and overflow: output_ready=0, fill two vectors (A: 1..4, B: 5..8) -> buffer_full=1; third write dropped, overflow_error=1. Raise ready -> stream 1,2,3,4, then 1 idle cycle, then 5,6,7,8; output_data held stable while stalled.
- Bad index: write idx 4 (CELL_AMOUNT=4) -> index_error=1, bitmap unchanged, no output.
- Duplicate: writes idx 1=3 then idx 1=6, then idx 0,2,3 -> with the macro: dup_error=1, stream element1=3; without the macro: element1=6, dup_error=0.
- Reset mid-stream: assert reset_n=0 after 2 accepted beats -> all outputs 0 immediately. After release, a fresh fill of 0..3 streams correctly from bank 0.
